// File: rtl/glitch_sequencer.sv
// Glitch timing core: latches the pulse configuration on arm, waits for a
// synchronized trigger edge, then emits a cycle-exact glitch pulse train.
module glitch_sequencer #(
  parameter int SYNC_STAGES      = 2,
  parameter bit TRIG_ACTIVE_HIGH = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigger_i,
  input  logic        arm_i,
  input  logic        abort_i,
  input  logic        pulse_en,
  input  logic [15:0] delay_i,
  input  logic [7:0]  width_i,
  input  logic [7:0]  num_pulses_i,
  input  logic [15:0] pulse_spacing_i,
  output logic        glitch_o,
  output logic        armed_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  pulse_count_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARMED = 3'd1;
  localparam logic [2:0] DELAY = 3'd2;
  localparam logic [2:0] PULSE = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [2:0]             state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   trig_prev;
  logic                   trig_sync;
  logic                   trig_edge;
  logic [15:0]            d_sh;
  logic [7:0]             w_sh;
  logic [7:0]             n_sh;
  logic [15:0]            s_sh;
  logic [15:0]            cnt;
  logic [7:0]             width_cnt;

  assign trig_sync = sync_q[SYNC_STAGES-1];
  assign trig_edge = TRIG_ACTIVE_HIGH ? (trig_sync & ~trig_prev) : (~trig_sync & trig_prev);
  assign armed_o   = (state == ARMED);
  assign busy_o    = (state == DELAY) || (state == PULSE) || (state == GAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      trig_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], trigger_i};
      trig_prev <= trig_sync;
    end
  end

  // Zero width and zero spacing are promoted to one cycle when latched so
  // the down-counters never start at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      glitch_o      <= 1'b0;
      done_o        <= 1'b0;
      pulse_count_o <= 8'd0;
      d_sh          <= 16'd0;
      w_sh          <= 8'd0;
      n_sh          <= 8'd0;
      s_sh          <= 16'd0;
      cnt           <= 16'd0;
      width_cnt     <= 8'd0;
    end else begin
      done_o <= 1'b0;
      if ((state != IDLE) && (abort_i || !pulse_en)) begin
        state    <= IDLE;
        glitch_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (arm_i && pulse_en) begin
              d_sh          <= delay_i;
              w_sh          <= (width_i == 8'd0) ? 8'd1 : width_i;
              n_sh          <= num_pulses_i;
              s_sh          <= (pulse_spacing_i == 16'd0) ? 16'd1 : pulse_spacing_i;
              pulse_count_o <= 8'd0;
              state         <= ARMED;
            end
          end
          ARMED: begin
            if (trig_edge) begin
              if (n_sh == 8'd0) begin
                done_o <= 1'b1;
                state  <= IDLE;
              end else if (d_sh == 16'd0) begin
                glitch_o      <= 1'b1;
                width_cnt     <= w_sh;
                pulse_count_o <= pulse_count_o + 8'd1;
                state         <= PULSE;
              end else begin
                cnt   <= d_sh;
                state <= DELAY;
              end
            end else if (arm_i) begin
              d_sh          <= delay_i;
              w_sh          <= (width_i == 8'd0) ? 8'd1 : width_i;
              n_sh          <= num_pulses_i;
              s_sh          <= (pulse_spacing_i == 16'd0) ? 16'd1 : pulse_spacing_i;
              pulse_count_o <= 8'd0;
            end
          end
          DELAY: begin
            if (cnt == 16'd1) begin
              glitch_o      <= 1'b1;
              width_cnt     <= w_sh;
              pulse_count_o <= pulse_count_o + 8'd1;
              state         <= PULSE;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          PULSE: begin
            // pulse_count_o already includes the current pulse, so equality
            // with N marks the final pulse of the train.
            if (width_cnt == 8'd1) begin
              glitch_o <= 1'b0;
              if (pulse_count_o == n_sh) begin
                done_o <= 1'b1;
                state  <= IDLE;
              end else begin
                cnt   <= s_sh;
                state <= GAP;
              end
            end else begin
              width_cnt <= width_cnt - 8'd1;
            end
          end
          GAP: begin
            if (cnt == 16'd1) begin
              glitch_o      <= 1'b1;
              width_cnt     <= w_sh;
              pulse_count_o <= pulse_count_o + 8'd1;
              state         <= PULSE;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          default: begin
            state    <= IDLE;
            glitch_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/glitch_sequencer.md
Name: glitch_sequencer

Overview:
Timing core of the glitcher. It takes the glitch configuration (delay, width, pulse count, spacing, enable) from the UART command handler and latches it when armed. It then waits for a rising edge on the external target trigger and drives the glitch output pulse train with cycle-exact timing. The handler sees status through busy/armed/done and a pulse counter.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the trigger synchronizer (min 2)
TRIG_ACTIVE_HIGH, 1, 1 = rising trigger edge fires; 0 = falling edge fires

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
trigger_i  input  1  external target trigger, asynchronous to clk
arm_i  input  1  single-cycle arm strobe from the command handler
abort_i  input  1  single-cycle abort strobe
pulse_en  input  1  global enable; low blocks arming and aborts an active sequence
delay_i  input  16  cycles from the trigger edge to the first pulse
width_i  input  8  high time per pulse, in cycles
num_pulses_i  input  8  pulses per sequence
pulse_spacing_i  input  16  low time between pulses, in cycles
glitch_o  output  1  registered glitch drive
armed_o  output  1  high while waiting for the trigger
busy_o  output  1  high from the trigger edge until the sequence ends
done_o  output  1  single-cycle strobe when a sequence completes normally
pulse_count_o  output  8  pulses started since the last arm

Behaviour:
- Reset (async, rst_n low): glitch_o=0, armed_o=0, busy_o=0, done_o=0, pulse_count_o=0, all counters 0, state IDLE. glitch_o falls without waiting for a clock edge.
- Trigger path: trigger_i goes through SYNC_STAGES flops, then one edge-detect flop. Let E be the cycle in which the detected edge (trig_edge) is high. Only an edge counts; a trigger already at the active level when armed does not fire.
- States: IDLE, ARMED, DELAY, PULSE, GAP.
- IDLE -> ARMED: arm_i=1 and pulse_en=1. Latch the config into shadow registers D, W, N, S. Clear pulse_count_o. armed_o=1 from the next cycle. arm_i with pulse_en=0 is ignored.
- ARMED -> DELAY: trig_edge=1. armed_o falls and busy_o rises in cycle E+1.
- Zero-value rules, applied at latch time:
  - W=0 is treated as 1.
  - S=0 is treated as 1, so pulses stay distinct.
  - N=0: no pulses. done_o=1 in cycle E+1, return to IDLE.
- Timing, N>=1, using the adjusted values:
  - Pulse k (k=0..N-1) has glitch_o high in cycles E+1+D+k*(W+S) through E+D+W+k*(W+S) inclusive, exactly W cycles each.
  - D=0 means glitch_o is high in E+1.
  - pulse_count_o increments in the first high cycle of each pulse.
- End of sequence:
  - After the last pulse falls, the block returns to IDLE with no trailing gap.
  - done_o=1 for exactly one cycle, the first low cycle after the last pulse: E+1+D+N*W+(N-1)*S.
  - busy_o=0 in that same cycle.
- One-shot: the block must be re-armed for each sequence. pulse_count_o holds its value until the next arm.
- arm_i while ARMED re-latches the config and stays in ARMED. arm_i while busy is ignored.
- Edges arriving during DELAY, PULSE or GAP are ignored; there is no retrigger.
- Abort: abort_i=1 or pulse_en=0 in any non-IDLE state has these effects in the next cycle:
  - glitch_o=0.
  - State IDLE, armed_o=0, busy_o=0.
  - done_o is not asserted; pulse_count_o holds.
  - abort takes priority over a trig_edge in the same cycle.
- Arithmetic: DELAY and GAP use down-counters of 16 bits, PULSE of 8 bits. Counts up to 0xFFFF must work with no overflow. The pulse counter is 8 bits, so N=255 yields pulse_count_o=255 with no wrap.
- Shadow registers isolate the sequence from config changes on the inputs once armed.

Test Plan:
- Arm with D=10, W=3, N=1, S=0, then raise trigger_i -> glitch_o high for exactly cycles E+11..E+13. done_o is high only at E+14, and pulse_count_o=1.
- D=0, W=2, N=3, S=4 -> glitch_o highs at E+1..E+2, E+7..E+8 and E+13..E+14. done_o at E+15, and pulse_count_o steps 1, 2, 3.
- trigger_i held high before arm_i, with no new edge -> the block stays ARMED, glitch_o stays 0 for 1000 cycles, armed_o=1. A low-high toggle then fires the sequence normally.
- D=100, W=50, N=2, with abort_i in the 10th pulse-high cycle -> glitch_o=0 the next cycle. busy_o=0, done_o never asserted, pulse_count_o=1.
- N=0, D=500 -> done_o at E+1 and glitch_o never rises. Also: arm_i with pulse_en=0 -> armed_o stays 0.
- rst_n pulled low mid-pulse (asynchronously, between clock edges) -> glitch_o drops before the next clk edge, and all outputs take their reset values. After release, the block sits in IDLE and ignores triggers until re-armed.
